// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its sweep checker.
package alu_pkg;

  localparam int W     = 4;
  localparam int IDX_W = 11;

  localparam logic [IDX_W-1:0] IDX_LAST = 11'h7FF;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

endpackage

// File: rtl/alu_golden.sv
// Combinational reference ALU the sweeper compares the real ALU against.
module alu_golden
  import alu_pkg::*;
(
  input  logic [2:0]   ctrl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         car,
  output logic         of
);

  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // subtract as a + ~b + 1 so car reads as "no borrow"
  assign diff = {1'b0, a} + {1'b0, ~b} + 5'd1;

  // opcode decode; flags stay 0 for everything but add/sub
  always_comb begin
    res = '0;
    car = 1'b0;
    of  = 1'b0;
    case (ctrl)
      OP_ADD: begin
        {car, res} = sum;
        of = (a[W-1] == b[W-1]) & (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        {car, res} = diff;
        of = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1]);
      end
      OP_NOT:  res = ~a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_LT:   res = {3'b000, ($signed(a) < $signed(b))};
      OP_EQ:   res = {3'b000, (a == b)};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_sweeper.sv
// Exhaustive (ctrl,a,b) sweep of the external ALU with error count and
// first-failing-vector capture.
module alu_sweeper
  import alu_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [2:0]   ctrl,
  input  logic [W-1:0] res,
  input  logic         car,
  input  logic         of,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [11:0]  err_cnt,
  output logic [10:0]  first_fail
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t           state, nstate;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cnt;
  logic [W-1:0]     smp_res;
  logic             smp_car, smp_of;
  logic [W-1:0]     g_res;
  logic             g_car, g_of;
  logic             go, last, mism;

  // vector fields are driven straight from the registered index
  assign ctrl = idx[10:8];
  assign a    = idx[7:4];
  assign b    = idx[3:0];

  alu_golden u_gold (
    .ctrl (ctrl),
    .a    (a),
    .b    (b),
    .res  (g_res),
    .car  (g_car),
    .of   (g_of)
  );

  assign go   = start & ((state == IDLE) | (state == DONE));
  assign last = (cnt == CNT_LAST);
  assign mism = {smp_res, smp_car, smp_of} != {g_res, g_car, g_of};

  assign busy = (state == APPLY) | (state == CHECK);
  assign done = (state == DONE);
  assign pass = done & (err_cnt == 12'd0);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // next state; start is only honoured from IDLE or DONE
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (go) nstate = APPLY;
      APPLY:   if (last) nstate = CHECK;
      CHECK:   nstate = (idx == IDX_LAST) ? DONE : APPLY;
      DONE:    if (go) nstate = APPLY;
      default: nstate = IDLE;
    endcase
  end

  // index, settle counter, sample capture and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      cnt        <= '0;
      smp_res    <= '0;
      smp_car    <= 1'b0;
      smp_of     <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            idx        <= '0;
            cnt        <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
          end
        end
        APPLY: begin
          if (last) begin
            cnt     <= '0;
            smp_res <= res;
            smp_car <= car;
            smp_of  <= of;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        CHECK: begin
          if (mism) begin
            err_cnt <= err_cnt + 12'd1;
            if (err_cnt == 12'd0) first_fail <= idx;
          end
          if (idx != IDX_LAST) idx <= idx + 11'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweeper.sv
// Scoreboard bench: bench-side ALU model (with fault modes) feeds two
// sweepers (SETTLE=1 and SETTLE=3); expected sweep outcomes are queued at
// start and checked by monitors when done rises.
module tb_alu_sweeper;

  typedef struct {
    int err;
    int ff;
    int pass;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;

  logic [3:0]  a1, b1, res1, a3, b3, res3;
  logic [2:0]  ctrl1, ctrl3;
  logic        car1, of1, car3, of3;
  logic        busy1, done1, pass1, busy3, done3, pass3;
  logic [11:0] err1, err3;
  logic [10:0] ff1, ff3;
  logic [5:0]  r1, r3;

  int mode = 0;
  int bad_idx = 0;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  exp_t q1[$], q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .ctrl(ctrl1),
    .res(res1), .car(car1), .of(of1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err1), .first_fail(ff1));

  alu_sweeper #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .ctrl(ctrl3),
    .res(res3), .car(car3), .of(of3), .busy(busy3), .done(done3),
    .pass(pass3), .err_cnt(err3), .first_fail(ff3));

  // plain-arithmetic ALU behaviour: {res, car, of}
  function automatic logic [5:0] ref_alu(int op, int a, int b);
    int r, c, o, sa, sb;
    c = 0; o = 0; r = 0;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    case (op)
      0: begin r = a + b; c = (r > 15); o = (sa + sb > 7) || (sa + sb < -8); end
      1: begin r = a - b; c = (a >= b); o = (sa - sb > 7) || (sa - sb < -8); end
      2: r = 15 - a;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (sa < sb);
      default: r = (a == b);
    endcase
    return {4'(r & 15), 1'(c), 1'(o)};
  endfunction

  // mode 0 clean, 1 car stuck at 0, 2 corrupt one vector, 3 literal spot values
  function automatic logic [5:0] alu_drv(logic [10:0] v, int md, int bad);
    logic [5:0] g;
    g = ref_alu(int'(v[10:8]), int'(v[7:4]), int'(v[3:0]));
    case (md)
      1: g[1] = 1'b0;
      2: if (int'(v) == bad) g[2] = ~g[2];
      3: case (v)
           11'h071: g = {4'h8, 1'b0, 1'b1};
           11'h101: g = {4'hF, 1'b0, 1'b0};
           11'h181: g = {4'h7, 1'b1, 1'b1};
           11'h6F0: g = {4'h1, 1'b0, 1'b0};
           11'h755: g = {4'h1, 1'b0, 1'b0};
           default: ;
         endcase
      default: ;
    endcase
    return g;
  endfunction

  always_comb begin
    r1 = alu_drv({ctrl1, a1, b1}, mode, bad_idx);
    r3 = alu_drv({ctrl3, a3, b3}, 0, 0);
  end
  assign {res1, car1, of1} = r1;
  assign {res3, car3, of3} = r3;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor for the SETTLE=1 sweeper
  logic done1_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done1 && !done1_q) begin
      if (q1.size() == 0) check("dut1 unexpected done", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1 err_cnt", int'(err1), e.err);
        check("dut1 first_fail", int'(ff1), e.ff);
        check("dut1 pass", int'(pass1), e.pass);
        check("dut1 done cycle", cyc, e.cyc);
        check("dut1 busy at done", int'(busy1), 0);
      end
    end
    done1_q = done1;
  end

  // scoreboard monitor for SETTLE=3, plus vector hold/advance tracking
  logic done3_q = 1'b0, busy3_q = 1'b0;
  int   b3s = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy3) begin
      if (!busy3_q) b3s = cyc;
      check("dut3 vector index", int'({ctrl3, a3, b3}), (cyc - b3s) / 4);
    end
    if (done3 && !done3_q) begin
      if (q3.size() == 0) check("dut3 unexpected done", 1, 0);
      else begin
        e = q3.pop_front();
        check("dut3 err_cnt", int'(err3), e.err);
        check("dut3 first_fail", int'(ff3), e.ff);
        check("dut3 pass", int'(pass3), e.pass);
        check("dut3 done cycle", cyc, e.cyc);
      end
    end
    busy3_q = busy3;
    done3_q = done3;
  end

  task automatic wait_done1(int budget);
    int k;
    k = 0;
    while (!done1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done1) check("dut1 done timeout", 0, 1);
  endtask

  task automatic push1(int err, int ff, int s);
    exp_t e;
    e.err = err; e.ff = ff; e.pass = (err == 0); e.cyc = s + 4097;
    q1.push_back(e);
  endtask

  task automatic check_zero(string name);
    check(name, int'({a1, b1, ctrl1, busy1, done1, pass1, err1, ff1}), 0);
  endtask

  initial begin
    int s, ncar, fcar;
    exp_t e;

    // reset values
    #12;
    check_zero("dut1 reset values");
    check("dut3 reset values", int'({a3, b3, ctrl3, busy3, done3, pass3, err3, ff3}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // clean sweep on both; extra starts while busy and on the final edge
    mode = 0;
    s = cyc;
    push1(0, 0, s);
    e.err = 0; e.ff = 0; e.pass = 1; e.cyc = s + 8193;
    q3.push_back(e);
    start1 = 1'b1; start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    check("dut1 busy after start", int'(busy1), 1);
    for (int k = 0; k < 4100; k++) begin
      @(negedge clk);
      start1 = (cyc == s + 10) || (cyc == s + 500) || (cyc == s + 4096);
    end
    start1 = 1'b0;
    check("dut1 done holds after final-edge start", int'(done1), 1);
    check("dut1 idle after final-edge start", int'(busy1), 0);

    // car stuck at 0; restart from DONE
    ncar = 0; fcar = -1;
    for (int v = 0; v < 2048; v++) begin
      logic [5:0] g;
      g = ref_alu(v >> 8, (v >> 4) & 15, v & 15);
      if (g[1]) begin
        ncar++;
        if (fcar < 0) fcar = v;
      end
    end
    mode = 1;
    s = cyc;
    push1(ncar, fcar, s);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("dut1 restart clears done", int'(done1), 0);
    check("dut1 restart clears err_cnt", int'(err1), 0);
    check("dut1 restart busy", int'(busy1), 1);
    wait_done1(4200);
    @(negedge clk);

    // single random corrupted vector
    mode = 2;
    bad_idx = $urandom_range(0, 2047);
    s = cyc;
    push1(1, bad_idx, s);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done1(4200);
    @(negedge clk);

    // reset mid-sweep, then a clean sweep driven with literal spot values
    mode = 3;
    s = cyc;
    push1(0, 0, s);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (cyc < s + 1000) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("dut1 values during reset");
    q1.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_zero("dut1 idle after reset release");
    s = cyc;
    push1(0, 0, s);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done1(4200);
    @(negedge clk);

    check("dut1 scoreboard drained", q1.size(), 0);
    check("dut3 scoreboard drained", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
